regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter.sv | 160 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares a single register-file write port among `cores` requesters. Each core
// owns a one-deep pending slot that it fills through a valid/ready handshake.
// A round-robin arbiter drains one slot per cycle into a registered write port.
// Writes that target register 0 free their slot and advance the pointer, but
// they never raise write_enable.
//
// Ports:
//   clk            clock, rising edge
//   reset_n        asynchronous active-low reset
//   req_valid      [cores] core i offers a writeback
//   req_ready      [cores] core i slot is free (flop-only, independent of req_valid)
//   req_address    [cores][addr_width] destination register per core
//   req_data       [cores][data_width] write data per core
//   write_enable   registered write strobe to the register file
//   write_address  registered write address (holds when idle)
//   write_data     registered write data (holds when idle)
//   write_core     index of the core whose write is on the port (holds when idle)
//   busy           any slot pending or write_enable high

module regfile_write_arbiter #(
    parameter int unsigned cores      = 4,
    parameter int unsigned data_width = 32,
    parameter int unsigned addr_width = 5,
    parameter int unsigned id_width   = (cores > 1) ? $clog2(cores) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [cores-1:0]                      req_valid,
    output logic [cores-1:0]                      req_ready,
    input  logic [cores-1:0][addr_width-1:0]      req_address,
    input  logic [cores-1:0][data_width-1:0]      req_data,
    output logic                                  write_enable,
    output logic [addr_width-1:0]                 write_address,
    output logic [data_width-1:0]                 write_data,
    output logic [id_width-1:0]                   write_core,
    output logic                                  busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [cores-1:0]                 pend_valid_q, pend_valid_d;
    logic [cores-1:0][addr_width-1:0] pend_addr_q,  pend_addr_d;
    logic [cores-1:0][data_width-1:0] pend_data_q,  pend_data_d;

    logic [id_width-1:0]              rr_ptr_q,     rr_ptr_d;

    logic                             we_q,         we_d;
    logic [addr_width-1:0]            waddr_q,      waddr_d;
    logic [data_width-1:0]            wdata_q,      wdata_d;
    logic [id_width-1:0]              wcore_q,      wcore_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                             grant_valid;
    logic [id_width-1:0]              grant_idx;
    logic [id_width-1:0]              cand_idx;

    // Scan rr_ptr, rr_ptr+1, ... circularly; the first pending slot wins.
    // Arithmetic is done at 32 bits so non-power-of-two core counts wrap
    // correctly instead of aliasing through the id_width truncation.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < cores; k++) begin
            cand_idx = id_width'((32'(rr_ptr_q) + k) % cores);
            if (!grant_valid && pend_valid_q[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake side
    // ------------------------------------------------------------------
    // Ready is a pure function of the slot flop so a core can never build a
    // combinational loop through valid -> ready.
    assign req_ready = ~pend_valid_q;

    // Slot next state. A slot cannot be both granted and captured on the same
    // edge: grant needs it full, capture needs it empty.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;

        if (grant_valid) begin
            pend_valid_d[grant_idx] = 1'b0;
        end

        for (int unsigned i = 0; i < cores; i++) begin
            if (req_valid[i] && !pend_valid_q[i]) begin
                pend_valid_d[i] = 1'b1;
                pend_addr_d[i]  = req_address[i];
                pend_data_d[i]  = req_data[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-port side
    // ------------------------------------------------------------------
    // Address, data and core follow every grant (including register 0 drops)
    // and hold otherwise; only the strobe is suppressed for register 0.
    always_comb begin
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wcore_d  = wcore_q;
        rr_ptr_d = rr_ptr_q;

        if (grant_valid) begin
            we_d     = |pend_addr_q[grant_idx];
            waddr_d  = pend_addr_q[grant_idx];
            wdata_d  = pend_data_q[grant_idx];
            wcore_d  = grant_idx;
            rr_ptr_d = id_width'((32'(grant_idx) + 32'd1) % cores);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid_q <= '0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            rr_ptr_q     <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wcore_q      <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            rr_ptr_q     <= rr_ptr_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wcore_q      <= wcore_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign write_enable  = we_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign write_core    = wcore_q;
    assign busy          = (|pend_valid_q) | we_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter (4 cores, 32-bit data, 5-bit
// address). A slot-level reference model tracks every pending writeback and
// the expected write port; a compare process checks the DUT on every falling
// edge. Directed scenarios add literal expectations, then a random phase runs.

module tb_regfile_write_arbiter;

    localparam int CORES = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int IW    = 2;

    logic                       clk;
    logic                       reset_n;
    logic [CORES-1:0]           req_valid;
    logic [CORES-1:0]           req_ready;
    logic [CORES-1:0][AW-1:0]   req_address;
    logic [CORES-1:0][DW-1:0]   req_data;
    logic                       write_enable;
    logic [AW-1:0]              write_address;
    logic [DW-1:0]              write_data;
    logic [IW-1:0]              write_core;
    logic                       busy;

    int n_vec;
    int n_err;

    regfile_write_arbiter #(
        .cores      (CORES),
        .data_width (DW),
        .addr_width (AW),
        .id_width   (IW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_address   (req_address),
        .req_data      (req_data),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .write_core    (write_core),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Register file fed by the DUT write port (no hardwired zero, so a stray
    // write to register 0 is visible).
    logic [DW-1:0] rf [32];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (write_enable) begin
            rf[write_address] <= write_data;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: slots plus a pointer; the winner is the pending core
    // at the smallest circular distance from the pointer.
    // ------------------------------------------------------------------
    logic [CORES-1:0] m_pv;
    logic [AW-1:0]    m_pa [CORES];
    logic [DW-1:0]    m_pd [CORES];
    int               m_rr;
    logic             m_we;
    logic [AW-1:0]    m_wa;
    logic [DW-1:0]    m_wd;
    int               m_wc;

    function automatic int pick(input logic [CORES-1:0] pv, input int rr);
        int best;
        int best_dist;
        best      = -1;
        best_dist = CORES;
        for (int c = 0; c < CORES; c++) begin
            if (pv[c] && ((c - rr + CORES) % CORES) < best_dist) begin
                best_dist = (c - rr + CORES) % CORES;
                best      = c;
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int win;
        logic [CORES-1:0] gmask;
        if (!reset_n) begin
            m_pv <= '0;
            m_rr <= 0;
            m_we <= 1'b0;
            m_wa <= '0;
            m_wd <= '0;
            m_wc <= 0;
        end else begin
            win   = pick(m_pv, m_rr);
            gmask = '0;
            if (win >= 0) begin
                gmask[win] = 1'b1;
                m_we <= (m_pa[win] != 0);
                m_wa <= m_pa[win];
                m_wd <= m_pd[win];
                m_wc <= win;
                m_rr <= (win + 1) % CORES;
            end else begin
                m_we <= 1'b0;
            end
            m_pv <= (m_pv | (req_valid & ~m_pv)) & ~gmask;
            for (int i = 0; i < CORES; i++) begin
                if (req_valid[i] && !m_pv[i]) begin
                    m_pa[i] <= req_address[i];
                    m_pd[i] <= req_data[i];
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin : compare
        logic [CORES-1:0] exp_rdy;
        logic             exp_busy;
        exp_rdy  = ~m_pv;
        exp_busy = (|m_pv) | m_we;
        chk("req_ready", req_ready, exp_rdy);
        chk("write_enable", write_enable, m_we);
        chk("write_address", write_address, m_wa);
        chk("write_data", write_data, m_wd);
        chk("write_core", write_core, m_wc);
        chk("busy", busy, exp_busy);
    end

    logic [DW-1:0] q3[$];
    logic [DW-1:0] exp3;
    logic          we_seen;

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        req_valid   = '0;
        req_address = '0;
        req_data    = '0;

        // Reset then idle.
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) begin
            tick();
            chk("idle_ready", req_ready, 4'b1111);
            chk("idle_we", write_enable, 1'b0);
            chk("idle_busy", busy, 1'b0);
        end

        // Round-robin burst, twice.
        for (int i = 0; i < CORES; i++) begin
            req_valid[i]   = 1'b1;
            req_address[i] = AW'(i + 1);
            req_data[i]    = DW'(32'hA + i);
        end
        tick();
        req_valid = '0;
        chk("burst_ready_full", req_ready, 4'b0000);
        for (int k = 0; k < CORES; k++) begin
            tick();
            chk("burst_we", write_enable, 1'b1);
            chk("burst_core", write_core, k);
            chk("burst_addr", write_address, k + 1);
            chk("burst_data", write_data, 32'hA + k);
            chk("burst_ready", req_ready, (1 << (k + 1)) - 1);
        end
        for (int i = 0; i < CORES; i++) begin
            req_valid[i] = 1'b1;
            req_data[i]  = DW'(32'h20 + i);
        end
        tick();
        req_valid = '0;
        chk("burst2_gap_we", write_enable, 1'b0);
        for (int k = 0; k < CORES; k++) begin
            tick();
            chk("burst2_core", write_core, k);
            chk("burst2_data", write_data, 32'h20 + k);
        end
        tick();

        // Single write from core 2.
        req_valid[2]   = 1'b1;
        req_address[2] = 5'b01111;
        req_data[2]    = 32'h15;
        tick();
        req_valid = '0;
        chk("single_ready", req_ready, 4'b1011);
        tick();
        chk("single_we", write_enable, 1'b1);
        chk("single_addr", write_address, 5'b01111);
        chk("single_data", write_data, 32'h15);
        chk("single_core", write_core, 2);
        tick();
        chk("single_we_drop", write_enable, 1'b0);
        chk("single_rf", rf[15], 32'h15);

        // Register 0 drop from core 1, then prove the pointer moved to 2.
        req_valid[1]   = 1'b1;
        req_address[1] = '0;
        req_data[1]    = 32'hFFFF_FFFF;
        tick();
        req_valid = '0;
        tick();
        chk("r0_we", write_enable, 1'b0);
        chk("r0_ready", req_ready, 4'b1111);
        chk("r0_busy", busy, 1'b0);
        chk("r0_core", write_core, 1);
        chk("r0_data", write_data, 32'hFFFF_FFFF);
        req_valid      = 4'b1001;
        req_address[0] = 5'd7;
        req_data[0]    = 32'h30;
        req_address[3] = 5'd8;
        req_data[3]    = 32'h33;
        tick();
        req_valid = '0;
        tick();
        chk("r0_next_core", write_core, 3);
        chk("r0_next_we", write_enable, 1'b1);
        tick();
        chk("r0_after_core", write_core, 0);
        tick();
        chk("r0_rf_zero", rf[0], 32'h0);

        // Backpressure: core 3 offers a new value every cycle beside cores 0/1.
        req_address[0] = 5'd9;
        req_address[1] = 5'd10;
        req_address[3] = 5'd11;
        for (int n = 0; n < 10; n++) begin
            req_valid   = 4'b1011;
            req_data[0] = $urandom;
            req_data[1] = $urandom;
            req_data[3] = DW'(32'h300 + n);
            if (req_ready[3]) q3.push_back(req_data[3]);
            tick();
            if (write_enable && write_core == 2'd3) begin
                exp3 = (q3.size() > 0) ? q3.pop_front() : 32'hDEAD_BEEF;
                chk("bp_order", write_data, exp3);
            end
        end
        req_valid = '0;
        repeat (6) begin
            tick();
            if (write_enable && write_core == 2'd3) begin
                exp3 = (q3.size() > 0) ? q3.pop_front() : 32'hDEAD_BEEF;
                chk("bp_order", write_data, exp3);
            end
        end
        chk("bp_left", q3.size(), 0);

        // Reset mid-operation with slots pending and a write on the port.
        req_valid      = 4'b0111;
        req_address[0] = 5'd1;
        req_address[1] = 5'd2;
        req_address[2] = 5'd3;
        tick();
        req_valid = '0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_we", write_enable, 1'b0);
        chk("rst_ready", req_ready, 4'b1111);
        chk("rst_busy", busy, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        we_seen = 1'b0;
        repeat (6) begin
            tick();
            we_seen = we_seen | write_enable;
        end
        chk("rst_no_issue", we_seen, 1'b0);

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < CORES; i++) begin
                req_valid[i]   = ($urandom_range(0, 1) == 1);
                req_address[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, 31));
                req_data[i]    = $urandom;
            end
            tick();
            if ($urandom_range(0, 399) == 0) begin
                #3;
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
        end
        req_valid = '0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
